// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial full-adder slice between two requesters.
// Optional subtract mode (A-B) is enabled by defining SERIAL_ADD_SCHED_SUB_EN.
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
`ifdef SERIAL_ADD_SCHED_SUB_EN
  input  logic             req0_sub,
`endif
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
`ifdef SERIAL_ADD_SCHED_SUB_EN
  input  logic             req1_sub,
`endif
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two half adders plus carry OR; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic p;
    p = a ^ b;
    return {(a & b) | (c & p), p ^ c};
  endfunction

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             rr;
  logic             owner;

  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sub;
  logic [1:0]       slice;
  logic [WIDTH-1:0] sum_next;

  // Grant only in IDLE; rr=1 means requester 1 is preferred on a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state == IDLE) && !rst) begin
      grant0 = req0_valid && (!req1_valid || !rr);
      grant1 = req1_valid && (!req0_valid || rr);
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a   = req0_a;
    sel_b   = req0_b;
    sel_sub = 1'b0;
    if (grant1) begin
      sel_a = req1_a;
      sel_b = req1_b;
`ifdef SERIAL_ADD_SCHED_SUB_EN
      sel_sub = req1_sub;
`endif
    end else begin
      sel_a = req0_a;
      sel_b = req0_b;
`ifdef SERIAL_ADD_SCHED_SUB_EN
      sel_sub = req0_sub;
`endif
    end
  end

  assign slice    = full_add(a_sr[0], b_sr[0], carry);
  assign sum_next = {slice[0], sum_sr[WIDTH-1:1]};

  // Scheduler FSM, serial datapath and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      rr        <= 1'b0;
      owner     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (grant0 || grant1) begin
            a_sr  <= sel_a;
            // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
            b_sr  <= sel_sub ? ~sel_b : sel_b;
            carry <= sel_sub;
            cnt   <= '0;
            owner <= grant1;
            rr    <= grant0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= slice[1];
          if (cnt == LAST) begin
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_next;
            rsp_cout  <= slice[1];
            rsp_id    <= owner;
            state     <= DONE;
          end else begin
            cnt   <= cnt + CW'(1);
            state <= RUN;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
// Scoreboard bench for serial_add_sched: a cycle model predicts grants, busy and
// response timing; expected results are queued at accept and popped on rsp_valid.
module tb_serial_add_sched;

  localparam int W = 8;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_sub, req1_sub;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   m_cnt = 0;
  logic m_rr  = 1'b0;

  always #5 clk = ~clk;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
`ifdef SERIAL_ADD_SCHED_SUB_EN
    .req0_sub   (req0_sub),
`endif
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
`ifdef SERIAL_ADD_SCHED_SUB_EN
    .req1_sub   (req1_sub),
`endif
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic id, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic sub);
    exp_t r;
    int   full;
    r.id = id;
    if (sub) begin
      r.sum  = W'(int'(a) - int'(b));
      r.cout = (a >= b);
    end else begin
      full   = int'(a) + int'(b);
      r.sum  = W'(full);
      r.cout = (full >= (1 << W));
    end
    return r;
  endfunction

  // Cycle model: m_cnt counts remaining busy cycles (RUN x W, DONE x 1).
  initial begin
    forever begin
      logic e0, e1;
      exp_t r;
      @(negedge clk);
      e0 = (m_cnt == 0) && !rst && req0_valid && (!req1_valid || !m_rr);
      e1 = (m_cnt == 0) && !rst && req1_valid && (!req0_valid || m_rr);
      check("req0_ready", 32'(req0_ready), 32'(e0));
      check("req1_ready", 32'(req1_ready), 32'(e1));
      check("busy", 32'(busy), 32'(m_cnt != 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_cnt == 1));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(r.id));
          check("rsp_sum", 32'(rsp_sum), 32'(r.sum));
          check("rsp_cout", 32'(rsp_cout), 32'(r.cout));
        end
      end
      if (rst) begin
        m_cnt = 0;
        m_rr  = 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt--;
      end else if (e0 || e1) begin
        if (e0) sb.push_back(predict(1'b0, req0_a, req0_b, req0_sub));
        else    sb.push_back(predict(1'b1, req1_a, req1_b, req1_sub));
        m_cnt = W + 1;
        m_rr  = e0;
      end
    end
  end

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_sub   = 1'b0; req1_sub   = 1'b0;
  endtask

  task automatic set0(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
  endtask

  task automatic set1(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
  endtask

  // One-cycle request from an idle DUT, then wait out the operation.
  task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub);
    @(posedge clk); #1;
    if (id) set1(a, b, sub);
    else    set0(a, b, sub);
    @(posedge clk); #1;
    idle_inputs();
    repeat (W + 2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    #1 rst = 1'b0;

    // Single requester add, overflow cases.
    send(1'b0, 8'h35, 8'h4A, 1'b0);
    send(1'b1, 8'hFF, 8'h01, 1'b0);
    send(1'b1, 8'h80, 8'h80, 1'b0);

    // Both held from reset: alternating grants 0,1,0,1.
    do_reset();
    @(posedge clk); #1;
    set0(8'h01, 8'h02, 1'b0);
    set1(8'h10, 8'h20, 1'b0);
    repeat (4 * (W + 2)) @(posedge clk);
    #1 idle_inputs();
    repeat (W + 2) @(posedge clk);

    // Reset on the 4th RUN edge drops the operation.
    @(posedge clk); #1;
    set1(8'hAA, 8'h55, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_rsp_sum", 32'(rsp_sum), 32'd0);
    check("abort_rsp_cout", 32'(rsp_cout), 32'd0);
    check("abort_rsp_id", 32'(rsp_id), 32'd0);
    @(posedge clk); #1;
    set0(8'h07, 8'h09, 1'b0);
    set1(8'h33, 8'h44, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (W + 2) @(posedge clk);

    // Valid pulse while busy is ignored.
    @(posedge clk); #1;
    set0(8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 set0(8'hEE, 8'hEE, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (W + 2) @(posedge clk);

    // Randomised back-to-back traffic.
    for (int i = 0; i < 6; i++) begin
      send(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0);
    end

`ifdef SERIAL_ADD_SCHED_SUB_EN
    send(1'b0, 8'h10, 8'h03, 1'b1);
    send(1'b1, 8'h03, 8'h10, 1'b1);
    send(1'b0, 8'h35, 8'h4A, 1'b0);
    send(1'b1, 8'h5A, 8'h5A, 1'b1);
`endif

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
